// File: rtl/icetap_jtag_tap_if.sv
// Pin-level bundle between the TAP controller and its neighbours: tms/tdi/icetap_tdo in,
// tdo plus the Moore state strobes and instruction selects out.
interface icetap_jtag_tap_if;
    logic tms;
    logic tdi;
    logic icetap_tdo;
    logic tdo;
    logic tdo_en;
    logic test_logic_reset;
    logic run_test_idle;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic scan_n_ir;
    logic extest_ir;
    logic idcode_ir;
    logic bypass_ir;

    modport slave (
        input  tms, tdi, icetap_tdo,
        output tdo, tdo_en, test_logic_reset, run_test_idle,
               capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir,
               scan_n_ir, extest_ir, idcode_ir, bypass_ir
    );

    modport master (
        output tms, tdi, icetap_tdo,
        input  tdo, tdo_en, test_logic_reset, run_test_idle,
               capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir,
               scan_n_ir, extest_ir, idcode_ir, bypass_ir
    );
endinterface

// File: rtl/icetap_jtag_tap.sv
// 1149.1 TAP controller in front of the icetap JTAG top: 16-state FSM, IR, BYPASS and tdo mux.
// Define ICETAP_JTAG_IDCODE_EN to add the 32-bit IDCODE register and make it the default IR.
module icetap_jtag_tap #(
    parameter int unsigned        IR_BITS      = 4,
    parameter logic [IR_BITS-1:0] IR_EXTEST    = IR_BITS'(0),
    parameter logic [IR_BITS-1:0] IR_IDCODE    = IR_BITS'(1),
    parameter logic [IR_BITS-1:0] IR_SCAN_N    = IR_BITS'(2),
    parameter logic [31:0]        IDCODE_VALUE = 32'h1000_0001
) (
    input  logic              tck,
    input  logic              reset,
    icetap_jtag_tap_if.slave  jtag
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IR_BITS-1:0] IR_CAPTURE = IR_BITS'(1);
`ifdef ICETAP_JTAG_IDCODE_EN
    localparam logic [IR_BITS-1:0] IR_DEFAULT = IR_IDCODE;
`else
    localparam logic [IR_BITS-1:0] IR_DEFAULT = '1;
`endif

    tap_state_e         state_q, state_d;
    logic [IR_BITS-1:0] ir_shift_q, ir_shift_d;
    logic [IR_BITS-1:0] ir_q, ir_d;
    logic               bypass_q, bypass_d;
    logic               sel_scan_n, sel_extest, sel_idcode, sel_bypass;
    logic               tdo_d;

    always_ff @(posedge tck) begin
        if (reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = jtag.tms ? TLR      : RTI;
            RTI:      state_d = jtag.tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = jtag.tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = jtag.tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = jtag.tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = jtag.tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = jtag.tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = jtag.tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = jtag.tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = jtag.tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = jtag.tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = jtag.tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = jtag.tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = jtag.tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = jtag.tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = jtag.tms ? SEL_DR   : RTI;
        endcase
    end

    // Active IR moves only on Update-IR or while parked in TLR; partial shifts never leak in.
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        bypass_d   = bypass_q;
        case (state_q)
            TLR:    ir_d       = IR_DEFAULT;
            CAP_IR: ir_shift_d = IR_CAPTURE;
            SH_IR:  ir_shift_d = {jtag.tdi, ir_shift_q[IR_BITS-1:1]};
            UPD_IR: ir_d       = ir_shift_q;
            CAP_DR: bypass_d   = 1'b0;
            SH_DR:  bypass_d   = jtag.tdi;
            default: ;
        endcase
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            ir_shift_q <= IR_CAPTURE;
            ir_q       <= IR_DEFAULT;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
            bypass_q   <= bypass_d;
        end
    end

`ifdef ICETAP_JTAG_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        case (state_q)
            CAP_DR:  idcode_d = IDCODE_VALUE;
            SH_DR:   idcode_d = {jtag.tdi, idcode_q[31:1]};
            default: ;
        endcase
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            idcode_q <= IDCODE_VALUE;
        end else begin
            idcode_q <= idcode_d;
        end
    end

    assign sel_idcode = (ir_q == IR_IDCODE);
`else
    logic unused_cfg;
    assign unused_cfg = ^{IDCODE_VALUE, IR_IDCODE};
    assign sel_idcode = 1'b0;
`endif

    assign sel_scan_n = (ir_q == IR_SCAN_N);
    assign sel_extest = (ir_q == IR_EXTEST);
    assign sel_bypass = ~(sel_scan_n | sel_extest | sel_idcode);

    always_comb begin
        tdo_d = 1'b0;
        if (state_q == SH_IR) begin
            tdo_d = ir_shift_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_scan_n || sel_extest) begin
                tdo_d = jtag.icetap_tdo;
            end else if (sel_bypass) begin
                tdo_d = bypass_q;
            end else begin
`ifdef ICETAP_JTAG_IDCODE_EN
                tdo_d = idcode_q[0];
`else
                tdo_d = 1'b0;
`endif
            end
        end
    end

    assign jtag.tdo              = tdo_d;
    assign jtag.tdo_en           = (state_q == SH_DR) || (state_q == SH_IR);
    assign jtag.test_logic_reset = (state_q == TLR);
    assign jtag.run_test_idle    = (state_q == RTI);
    assign jtag.capture_dr       = (state_q == CAP_DR);
    assign jtag.shift_dr         = (state_q == SH_DR);
    assign jtag.update_dr        = (state_q == UPD_DR);
    assign jtag.capture_ir       = (state_q == CAP_IR);
    assign jtag.shift_ir         = (state_q == SH_IR);
    assign jtag.update_ir        = (state_q == UPD_IR);
    assign jtag.scan_n_ir        = sel_scan_n;
    assign jtag.extest_ir        = sel_extest;
    assign jtag.idcode_ir        = sel_idcode;
    assign jtag.bypass_ir        = sel_bypass;

endmodule

// File: tb/tb_icetap_jtag_tap.sv
// Bench for icetap_jtag_tap: directed scans plus random tms/tdi/reset traffic, every cycle
// compared against a table-driven TAP model. Honours ICETAP_JTAG_IDCODE_EN like the design.
module tb_icetap_jtag_tap;

    localparam int          IR_BITS  = 4;
    localparam logic [31:0] IDC_VAL  = 32'h1000_0001;
`ifdef ICETAP_JTAG_IDCODE_EN
    localparam bit          IDC_EN   = 1'b1;
    localparam logic [3:0]  IR_DEF   = 4'h1;
    localparam logic [3:0]  SEL_DEF  = 4'b0010;
`else
    localparam bit          IDC_EN   = 1'b0;
    localparam logic [3:0]  IR_DEF   = 4'hF;
    localparam logic [3:0]  SEL_DEF  = 4'b0001;
`endif

    // model state numbering: TLR, RTI, then a 7-state column per register (DR base 2, IR base 9)
    localparam int S_TLR = 0, S_RTI = 1, DR = 2, IR = 9;
    localparam int O_SEL = 0, O_CAP = 1, O_SH = 2, O_EX1 = 3, O_PAU = 4, O_EX2 = 5, O_UPD = 6;

    logic tck;
    logic reset;
    icetap_jtag_tap_if jtag ();

    icetap_jtag_tap dut (
        .tck   (tck),
        .reset (reset),
        .jtag  (jtag.slave)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          nxt0 [16];
    int          nxt1 [16];
    int          m_st   = S_TLR;
    logic [3:0]  m_ir   = IR_DEF;
    logic [3:0]  m_irsh = 4'h1;
    logic        m_byp  = 1'b0;
    logic [31:0] m_idc  = IDC_VAL;

    initial begin
        nxt0[S_TLR] = S_RTI; nxt1[S_TLR] = S_TLR;
        nxt0[S_RTI] = S_RTI; nxt1[S_RTI] = DR + O_SEL;
        for (int c = 0; c < 2; c++) begin
            int b;
            b = (c == 0) ? DR : IR;
            nxt0[b+O_SEL] = b + O_CAP; nxt1[b+O_SEL] = (c == 0) ? IR + O_SEL : S_TLR;
            nxt0[b+O_CAP] = b + O_SH;  nxt1[b+O_CAP] = b + O_EX1;
            nxt0[b+O_SH]  = b + O_SH;  nxt1[b+O_SH]  = b + O_EX1;
            nxt0[b+O_EX1] = b + O_PAU; nxt1[b+O_EX1] = b + O_UPD;
            nxt0[b+O_PAU] = b + O_PAU; nxt1[b+O_PAU] = b + O_EX2;
            nxt0[b+O_EX2] = b + O_SH;  nxt1[b+O_EX2] = b + O_UPD;
            nxt0[b+O_UPD] = S_RTI;     nxt1[b+O_UPD] = DR + O_SEL;
        end
    end

    task automatic model_edge(input bit t, input bit d, input bit r);
        if (r) begin
            m_st = S_TLR;
            m_ir = IR_DEF;
        end else begin
            if (m_st == S_TLR)        m_ir = IR_DEF;
            if (m_st == IR + O_CAP)   m_irsh = 4'h1;
            if (m_st == IR + O_SH)    m_irsh = (m_irsh >> 1) | (4'(d) << (IR_BITS - 1));
            if (m_st == IR + O_UPD)   m_ir = m_irsh;
            if (m_st == DR + O_CAP) begin m_byp = 1'b0; m_idc = IDC_VAL; end
            if (m_st == DR + O_SH) begin  m_byp = d; m_idc = (m_idc >> 1) | (32'(d) << 31); end
            m_st = t ? nxt1[m_st] : nxt0[m_st];
        end
    endtask

    function automatic logic [3:0] exp_sel();
        logic sc, ex, id;
        sc = (m_ir == 4'h2);
        ex = (m_ir == 4'h0);
        id = IDC_EN && (m_ir == 4'h1);
        return {sc, ex, id, ~(sc | ex | id)};
    endfunction

    function automatic logic exp_tdo();
        logic [3:0] s;
        s = exp_sel();
        if (m_st == IR + O_SH) return m_irsh[0];
        if (m_st != DR + O_SH) return 1'b0;
        if (s[3] || s[2])      return jtag.icetap_tdo;
        if (s[1])              return m_idc[0];
        return m_byp;
    endfunction

    task automatic compare_all();
        logic [7:0] es, as;
        es = {m_st == S_TLR, m_st == S_RTI, m_st == DR + O_CAP, m_st == DR + O_SH,
              m_st == DR + O_UPD, m_st == IR + O_CAP, m_st == IR + O_SH, m_st == IR + O_UPD};
        as = {jtag.test_logic_reset, jtag.run_test_idle, jtag.capture_dr, jtag.shift_dr,
              jtag.update_dr, jtag.capture_ir, jtag.shift_ir, jtag.update_ir};
        check_val("strobes", 32'(as), 32'(es));
        check_val("selects", 32'({jtag.scan_n_ir, jtag.extest_ir, jtag.idcode_ir, jtag.bypass_ir}),
                  32'(exp_sel()));
        check_val("tdo", 32'(jtag.tdo), 32'(exp_tdo()));
        check_val("tdo_en", 32'(jtag.tdo_en), 32'((m_st == DR + O_SH) || (m_st == IR + O_SH)));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit t, input bit d, input bit r);
        @(negedge tck);
        jtag.tms        = t;
        jtag.tdi        = d;
        jtag.icetap_tdo = 1'($urandom);
        reset           = r;
        @(posedge tck);
        model_edge(t, d, r);
        #1;
        compare_all();
    endtask

    task automatic tap_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
    endtask

    task automatic goto_shdr();   // from RTI
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] v, output logic [3:0] seen);
        tap_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < IR_BITS; i++) begin
            seen[i] = jtag.tdo;
            step(i == IR_BITS - 1, v[i], 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]  seen;
        logic [3:0]  pattern;
        logic [31:0] word;
        int          en_cnt;

        jtag.tms = 1'b1; jtag.tdi = 1'b0; jtag.icetap_tdo = 1'b0; reset = 1'b1;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check_val("rst_tlr", 32'(jtag.test_logic_reset), 32'd1);
        check_val("rst_sel", 32'({jtag.scan_n_ir, jtag.extest_ir, jtag.idcode_ir, jtag.bypass_ir}),
                  32'(SEL_DEF));
        check_val("rst_tdo_en", 32'(jtag.tdo_en), 32'd0);

        // SCAN_N load: capture pattern shifts out as 1,0,0,0
        load_ir(4'h2, seen);
        check_val("ir_capture_tdo", 32'(seen), 32'h1);
        check_val("scan_n_sel", 32'({jtag.scan_n_ir, jtag.extest_ir, jtag.idcode_ir, jtag.bypass_ir}),
                  32'b1000);

        // passthrough of icetap_tdo, then Pause-DR quiet
        goto_shdr();
        jtag.icetap_tdo = 1'b1; #1;
        check_val("pass_hi", 32'(jtag.tdo), 32'd1);
        jtag.icetap_tdo = 1'b0; #1;
        check_val("pass_lo", 32'(jtag.tdo), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("pause_tdo_en", 32'(jtag.tdo_en), 32'd0);
        check_val("pause_shift_dr", 32'(jtag.shift_dr), 32'd0);

        // TLR escape from Shift-DR
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_val("tlr_escape", 32'(jtag.test_logic_reset), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check_val("tlr_ir_default", 32'({jtag.scan_n_ir, jtag.extest_ir, jtag.idcode_ir, jtag.bypass_ir}),
                  32'(SEL_DEF));

`ifdef ICETAP_JTAG_IDCODE_EN
        // IDCODE read straight out of reset
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        goto_shdr();
        en_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            word[i] = jtag.tdo;
            if (jtag.tdo_en) en_cnt++;
            step(i == 31, 1'($urandom), 1'b0);
        end
        check_val("idcode_read", word, IDC_VAL);
        check_val("idcode_tdo_en", 32'(en_cnt), 32'd32);
`endif

        // BYPASS: one-cycle delay, first bit 0
        load_ir(4'hF, seen);
        goto_shdr();
        pattern = 4'b1101;   // tdi 1,0,1,1 LSB-first
        for (int i = 0; i < 4; i++) begin
            seen[i] = jtag.tdo;
            step(1'b0, pattern[i], 1'b0);
        end
        check_val("bypass_tdo", 32'(seen), 32'b1010);

        // reset in the middle of an IR shift
        load_ir(4'h0, seen);
        check_val("extest_sel", 32'({jtag.scan_n_ir, jtag.extest_ir, jtag.idcode_ir, jtag.bypass_ir}),
                  32'b0100);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_val("midshift_tlr", 32'(jtag.test_logic_reset), 32'd1);
        check_val("midshift_no_upd", 32'(jtag.update_ir), 32'd0);
        check_val("midshift_ir", 32'({jtag.scan_n_ir, jtag.extest_ir, jtag.idcode_ir, jtag.bypass_ir}),
                  32'(SEL_DEF));

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) < 4), 1'($urandom), ($urandom_range(0, 149) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/icetap_jtag_tap.md
Name: icetap_jtag_tap

Overview:
- IEEE 1149.1-style TAP controller that sits directly upstream of the icetap JTAG top.
- Runs the 16-state TAP FSM on tms and holds the instruction register.
- Decodes instructions into the state strobes and instruction selects that the icetap JTAG top consumes (test_logic_reset, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir).
- Owns the BYPASS and optional IDCODE data registers, and muxes the final tdo.

Parameters:
- IR_BITS, 4, instruction register width (>=2).
- IR_EXTEST, 4'h0, EXTEST opcode.
- IR_IDCODE, 4'h1, IDCODE opcode.
- IR_SCAN_N, 4'h2, SCAN_N opcode.
- IDCODE_VALUE, 32'h1000_0001, IDCODE value; bit 0 must be 1.
- BYPASS opcode is all-ones; all unassigned opcodes also select BYPASS.

Ports:
- tck  in  1  TAP clock; all state is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tms  in  1  test mode select.
- tdi  in  1  test data in.
- icetap_tdo  in  1  serial output from the icetap JTAG top.
- tdo  out  1  test data out.
- tdo_en  out  1  high in Shift-DR or Shift-IR.
- test_logic_reset  out  1  FSM is in Test-Logic-Reset.
- run_test_idle  out  1  FSM is in Run-Test/Idle.
- capture_dr / shift_dr / update_dr  out  1 each  FSM is in the named DR state.
- capture_ir / shift_ir / update_ir  out  1 each  FSM is in the named IR state.
- scan_n_ir  out  1  active IR == IR_SCAN_N.
- extest_ir  out  1  active IR == IR_EXTEST.
- idcode_ir  out  1  active IR == IR_IDCODE (feature enabled only).
- bypass_ir  out  1  any other opcode.

Behaviour:
- FSM: standard 16 states (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the IR equivalents). Transitions per 1149.1 on tms at the tck rising edge.
- From any state, five consecutive tms=1 edges reach TLR.
- All state outputs are Moore decodes of the registered state. Each is high for exactly the cycle the FSM occupies that state.
- reset=1: next state is TLR and the active IR loads its default (IDCODE if enabled, else all-ones). reset wins over tms.
- Reset values after the reset edge:
  - test_logic_reset=1; all other state strobes 0.
  - tdo_en=0.
  - With the feature: idcode_ir=1, bypass_ir=0.
  - Without the feature: bypass_ir=1.
  - scan_n_ir=0, extest_ir=0.
- Being in TLR also forces the active IR to its default on every cycle.
- IR shift register (IR_BITS):
  - CapIR loads {0...0,01}.
  - ShIR shifts right: tdi enters the MSB, the LSB goes to tdo.
  - UpdIR copies it into the active IR. The new selects are valid the cycle after UpdIR, i.e. in the next state.
  - Pause/Exit states hold all registers.
- Active IR changes only on UpdIR or TLR. Instruction selects are one-hot at all times.
- BYPASS register: 1 bit; CapDR loads 0; ShDR loads tdi.
- IDCODE register: 32 bits; CapDR loads IDCODE_VALUE; ShDR shifts right with tdi entering bit 31.
- tdo mux (combinational from registered sources):
  - ShIR: IR shift LSB.
  - ShDR with scan_n_ir or extest_ir: icetap_tdo.
  - ShDR with idcode_ir: IDCODE LSB.
  - ShDR with bypass_ir: bypass bit.
  - Otherwise: 0.
- tdo_en = shift_dr | shift_ir.
- DR capture/shift/update strobes are driven regardless of the selected instruction. The downstream block qualifies them with scan_n_ir/extest_ir.
- Reset asserted mid-shift: FSM goes to TLR on the next edge and partial IR shift contents are discarded (the active IR is not updated).

Optional Feature:
- Macro: ICETAP_JTAG_IDCODE_EN.
- Defined:
  - IDCODE register present.
  - Default IR = IR_IDCODE.
  - idcode_ir output is functional.
- Undefined:
  - No IDCODE register.
  - IR_IDCODE decodes as BYPASS.
  - Default IR = all-ones.
  - idcode_ir is tied to 0.

Test Plan:
- TLR escape: after reset, apply tms=1,1,1,1,1 from ShDR -> test_logic_reset=1 on the 5th edge; active IR = default.
- IR load SCAN_N: tms path TLR->RTI->SelDR->SelIR->CapIR->ShIR, shift tdi=0,1,0,0 LSB-first -> tdo emits 1,0,0,0; after UpdIR scan_n_ir=1 and the others are 0.
- IDCODE read (feature on): reset, go to ShDR, 32 shifts -> tdo returns 0x1000_0001 LSB-first, and tdo_en=1 throughout.
- BYPASS: load IR=4'hF, shift DR with tdi=1,0,1,1 -> tdo=0,1,0,1 (one-cycle delay, first bit 0).
- Passthrough: with scan_n_ir=1 in ShDR, toggle icetap_tdo -> tdo follows combinationally; on Pause-DR, tdo_en=0 and shift_dr=0.
- Reset mid-IR-shift: assert reset in ShIR after 2 bits -> TLR next cycle, active IR = default, no update_ir pulse.
